// File: rtl/seg_scan_disp.sv
// Four-digit multiplexed seven-segment scanner for a 16-bit counter value,
// with a frame-coherent snapshot, leading-zero blanking and a stretched carry indicator.
module seg_scan_disp #(
  parameter int DIV_W     = 17,
  parameter int RC_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cnt,
  input  logic        Rc,
  input  logic        freeze,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int STR_W = (RC_FRAMES < 1) ? 1 : $clog2(RC_FRAMES + 1);
  localparam logic [STR_W-1:0] STR_LOAD = STR_W'(RC_FRAMES);

  logic [DIV_W-1:0] presc_q, presc_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [STR_W-1:0] str_q, str_d;
  logic             upd_q, upd_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic       tick;
  logic       frame_end;
  logic       z3, z2, z1;
  logic [3:0] blank;
  logic [3:0] nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  always_comb begin
    tick      = &presc_q;
    frame_end = tick && (idx_q == 2'd3);

    presc_d  = presc_q + DIV_W'(1);
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    shadow_d = (frame_end && !freeze) ? cnt : shadow_q;
    upd_d    = tick;

    // Rc reload beats the frame-boundary decrement
    str_d = str_q;
    if (Rc) begin
      str_d = STR_LOAD;
    end else if (frame_end && (str_q != '0)) begin
      str_d = str_q - STR_W'(1);
    end

    z3    = blank_lz && (shadow_q[15:12] == 4'h0);
    z2    = z3 && (shadow_q[11:8] == 4'h0);
    z1    = z2 && (shadow_q[7:4] == 4'h0);
    blank = {z3, z2, z1, 1'b0};
    nib   = shadow_q[{idx_q, 2'b00} +: 4];

    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (upd_q) begin
      if (blank[idx_q]) begin
        an_d  = 4'b1111;
        seg_d = 7'h7F;
      end else begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = ~hex7(nib);
      end
      dp_d = !((idx_q == 2'd0) && (str_q != '0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      str_q    <= '0;
      upd_q    <= 1'b0;
      an_q     <= 4'b1111;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      str_q    <= str_d;
      upd_q    <= upd_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
